hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 18 +
 rtl/forward_unit.sv | 24 ++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: operand forward selects,
// multiply sequencing states and the default multiply latency.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } state_t;

    localparam int MUL_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/forward_unit.sv
// Operand forward select for one Execute source register; the M stage wins
// over W, and r15 (the PC) is never forwarded.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [3:0] RAE,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output fwd_sel_t   ForwardE
);

    always_comb begin
        ForwardE = FWD_RF;
        if (RAE != 4'hF) begin
            if (RegWriteM && (WA3M == RAE))
                ForwardE = FWD_M;
            else if (RegWriteW && (WA3W == RAE))
                ForwardE = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush
// and a counter-driven freeze of the front end during multi-cycle multiplies.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       BranchTakenE,
    input  logic       MulStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       Busy
);

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       ldr_stall;
    fwd_sel_t   fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .RAE       (RA1E),
        .WA3M      (WA3M),
        .WA3W      (WA3W),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardE  (fwd_a)
    );

    forward_unit u_fwd_b (
        .RAE       (RA2E),
        .WA3M      (WA3M),
        .WA3W      (WA3W),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardE  (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    assign ldr_stall = MemtoRegE && RegWriteE && (WA3E != 4'hF) &&
                       ((RA1D == WA3E) || (RA2D == WA3E));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // The counter is loaded with MUL_CYCLES-2 because the start cycle itself
    // (in RUN) already counts as one cycle of E-stage occupancy.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        Busy       = 1'b0;
        case (state)
            RUN: begin
                StallF = ldr_stall && !BranchTakenE;
                StallD = ldr_stall && !BranchTakenE;
                FlushD = BranchTakenE;
                FlushE = ldr_stall || BranchTakenE;
                if (MulStartE && !BranchTakenE) begin
                    next_state = MULWAIT;
                    next_cnt   = 4'(MUL_CYCLES - 2);
                end
            end
            MULWAIT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
                Busy   = 1'b1;
                if (cnt == 4'd0)
                    next_state = RUN;
                else
                    next_cnt = cnt - 4'd1;
            end
            default: next_state = RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed
// expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       reset;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       regwritee, regwritem, regwritew;
        logic       memtorege, branchtakene, mulstarte;
    } in_t;

    // Packed expectation: {fa, fb, stallF, stallD, stallE, flushD, flushE, flushM, busy}
    localparam logic [6:0] CT_IDLE = 7'b0000000;
    localparam logic [6:0] CT_MUL  = 7'b1110011;
    localparam logic [6:0] CT_LDS  = 7'b1100100;
    localparam logic [6:0] CT_BRF  = 7'b0001100;

    logic       clk;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, Busy;

    logic [10:0] expq[$];
    string       nameq[$];
    int          compared   = 0;
    int          mismatched = 0;

    hazard_ctrl #(.MUL_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .MulStartE    (MulStartE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .Busy         (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [6:0] ctl);
        return {fa, fb, ctl};
    endfunction

    task automatic drive(input in_t v);
        reset        = v.reset;
        RA1D         = v.ra1d;
        RA2D         = v.ra2d;
        RA1E         = v.ra1e;
        RA2E         = v.ra2e;
        WA3E         = v.wa3e;
        WA3M         = v.wa3m;
        WA3W         = v.wa3w;
        RegWriteE    = v.regwritee;
        RegWriteM    = v.regwritem;
        RegWriteW    = v.regwritew;
        MemtoRegE    = v.memtorege;
        BranchTakenE = v.branchtakene;
        MulStartE    = v.mulstarte;
    endtask

    task automatic applyStimulus(input in_t v, input logic [10:0] e, input string name);
        @(posedge clk);
        #1;
        drive(v);
        expq.push_back(e);
        nameq.push_back(name);
    endtask

    task automatic checkOutput(input logic [10:0] e, input string name);
        logic [10:0] act;
        act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, Busy};
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, e);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            logic [10:0] e;
            string       n;
            e = expq.pop_front();
            n = nameq.pop_front();
            checkOutput(e, n);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_t v;
        v = '0;
        v.reset = 1'b1;
        drive(v);
        repeat (2) @(posedge clk);
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "reset_state");

        v = '0;
        v.regwritem = 1; v.wa3m = 4'd3; v.regwritew = 1; v.wa3w = 4'd3;
        v.ra1e = 4'd3; v.ra2e = 4'd3;
        applyStimulus(v, ex(2'b10, 2'b10, CT_IDLE), "fwd_m_priority");
        v.regwritem = 0;
        applyStimulus(v, ex(2'b01, 2'b01, CT_IDLE), "fwd_w_only");
        v.regwritem = 1; v.wa3m = 4'hF; v.wa3w = 4'hF; v.ra1e = 4'hF; v.ra2e = 4'hF;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "fwd_r15_blocked");
        v.wa3m = 4'd2; v.wa3w = 4'd7; v.ra1e = 4'd7; v.ra2e = 4'd2;
        applyStimulus(v, ex(2'b01, 2'b10, CT_IDLE), "fwd_mixed");
        v.ra1e = 4'd1; v.ra2e = 4'd0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "fwd_none");

        v = '0;
        v.memtorege = 1; v.regwritee = 1; v.wa3e = 4'd5; v.ra2d = 4'd5;
        applyStimulus(v, ex(2'b00, 2'b00, CT_LDS), "ldr_stall");
        v = '0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "ldr_stall_released");
        v.memtorege = 1; v.regwritee = 1; v.wa3e = 4'd5; v.ra2d = 4'd5; v.branchtakene = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_BRF), "branch_over_ldr");
        v = '0;
        v.memtorege = 1; v.regwritee = 1; v.wa3e = 4'hF; v.ra1d = 4'hF;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "ldr_r15_excluded");
        v.wa3e = 4'd6; v.ra1d = 4'd6; v.regwritee = 0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "ldr_no_regwrite");
        v.regwritee = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_LDS), "ldr_stall_ra1d");
        v = '0; v.branchtakene = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_BRF), "branch_alone");

        // Single multiply, with load-use and branch ignored mid-wait
        v = '0; v.mulstarte = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "mul_start");
        for (int i = 1; i <= 3; i++) begin
            v = '0;
            if (i == 2) begin
                v.memtorege = 1; v.regwritee = 1; v.wa3e = 4'd5; v.ra2d = 4'd5;
                v.branchtakene = 1;
            end
            applyStimulus(v, ex(2'b00, 2'b00, CT_MUL), $sformatf("mul_wait_%0d", i));
        end
        v = '0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "mul_release");

        // Back-to-back multiplies
        v = '0; v.mulstarte = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "b2b_start1");
        v = '0;
        for (int i = 1; i <= 3; i++)
            applyStimulus(v, ex(2'b00, 2'b00, CT_MUL), $sformatf("b2b_wait1_%0d", i));
        v.mulstarte = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "b2b_start2");
        v = '0;
        for (int i = 1; i <= 3; i++)
            applyStimulus(v, ex(2'b00, 2'b00, CT_MUL), $sformatf("b2b_wait2_%0d", i));
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "b2b_release");

        // Reset abandons a multiply in progress
        v = '0; v.mulstarte = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "rst_mul_start");
        v = '0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_MUL), "rst_mul_wait");
        v.reset = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_MUL), "rst_mul_reset_cycle");
        v = '0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "rst_mul_after");

        v = '0; v.reset = 1; v.mulstarte = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "rst_over_mulstart");
        v = '0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "rst_over_mulstart_next");

        v = '0; v.mulstarte = 1; v.branchtakene = 1;
        applyStimulus(v, ex(2'b00, 2'b00, CT_BRF), "mul_with_branch");
        v = '0;
        applyStimulus(v, ex(2'b00, 2'b00, CT_IDLE), "mul_with_branch_next");

        for (int i = 0; i < 5 && expq.size() > 0; i++)
            @(posedge clk);
        if (expq.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
